// File: rtl/tt_um_tdm_demux_2ch.sv
// Receive end of a 2:1 bit-interleaved serial link: deserializes one nibble per
// channel from each sync-marked 8-slot frame and presents both on uo_out.
module tt_um_tdm_demux_2ch (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t     state_q;
  logic [2:0] slot_q;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [7:0] out_q;
  logic       done_q;
  logic       err_q;

  logic ser_bit, bit_valid, frame_sync;

  assign ser_bit    = ui_in[0];
  assign bit_valid  = ui_in[1];
  assign frame_sync = ui_in[2];

  always_comb begin
    a_d = {a_q[2:0], ser_bit};
    b_d = {b_q[2:0], ser_bit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bit_valid) begin
        if (frame_sync) begin
          // A sync inside a frame restarts it; stale shift bits are flushed
          // out before the restarted frame can complete.
          if (state_q == RECV) err_q <= 1'b1;
          a_q     <= a_d;
          slot_q  <= 3'd1;
          state_q <= RECV;
        end else if (state_q == RECV) begin
          if (slot_q[0]) b_q <= b_d;
          else           a_q <= a_d;
          if (slot_q == 3'd7) begin
            // Slot 7 carries B0; A is already complete in a_q.
            out_q   <= {b_d, a_q};
            done_q  <= 1'b1;
            slot_q  <= '0;
            state_q <= IDLE;
          end else begin
            slot_q <= slot_q + 3'd1;
          end
        end
      end
    end
  end

  assign uo_out  = out_q;
  assign uio_out = {2'b00, slot_q, (state_q == RECV), err_q, done_q};
  assign uio_oe  = '1;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, ui_in[7:3], uio_in};

endmodule

// File: tb/tb_tt_um_tdm_demux_2ch.sv
// Directed bench for the two-channel TDM demultiplexer; every comparison is an
// immediate assertion against a hand-derived value.
module tb_tt_um_tdm_demux_2ch;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_chk;
  int n_fail;

  tt_um_tdm_demux_2ch dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic b, input logic v, input logic s);
    @(negedge clk);
    ui_in = {5'b00000, s, v, b};
    @(posedge clk);
    #1;
  endtask

  // Sends one complete frame with sync on slot 0. prev_out is the value uo_out
  // must hold until the last slot; gaps inserts 1-3 invalid cycles (with sync
  // asserted, which must be ignored) between slots.
  task automatic frame(input logic [7:0] val, input logic [7:0] prev_out,
                       input logic err_exp, input bit gaps);
    logic [7:0] wire_bits;
    logic [2:0] slot_exp;
    wire_bits = {val[3], val[7], val[2], val[6], val[1], val[5], val[0], val[4]};
    for (int k = 0; k < 8; k++) begin
      step(wire_bits[7-k], 1'b1, (k == 0));
      if (k < 7) begin
        slot_exp = 3'(k + 1);
        chk("mid_status", uio_out, {2'b00, slot_exp, 1'b1, err_exp, 1'b0});
        chk("mid_hold_out", uo_out, prev_out);
        if (gaps) begin
          for (int g = 0; g <= (k % 3); g++) begin
            step(1'b1, 1'b0, 1'b1);
            chk("gap_status", uio_out, {2'b00, slot_exp, 1'b1, err_exp, 1'b0});
          end
        end
      end else begin
        chk("frame_out", uo_out, val);
        chk("frame_done", uio_out, {5'b00000, 1'b0, err_exp, 1'b1});
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    ena    = 1'b1;
    uio_in = 8'h00;
    ui_in  = 8'h00;
    rst_n  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_uo_out", uo_out, 8'h00);
    chk("rst_uio_out", uio_out, 8'h00);
    chk("rst_uio_oe", uio_oe, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain frame, valid every cycle.
    frame(8'h5A, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("done_clears", uio_out, 8'h00);
    chk("out_holds", uo_out, 8'h5A);

    // Same frame with invalid gaps between slots.
    frame(8'h5A, 8'h5A, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("gap_done_clears", uio_out, 8'h00);

    // Unsynced bits while idle are discarded.
    for (int i = 0; i < 5; i++) begin
      step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
      chk("idle_discard", uio_out, 8'h00);
      chk("idle_out", uo_out, 8'h5A);
    end
    frame(8'hC3, 8'h5A, 1'b0, 1'b0);

    // Aborted frame: sync + 3 bits, then a resync starting a full frame.
    frame(8'h5A, 8'hC3, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("partial_status", uio_out, {2'b00, 3'd4, 1'b1, 1'b0, 1'b0});
    frame(8'h0F, 8'h5A, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("err_sticky", uio_out, 8'h02);
    chk("after_abort_out", uo_out, 8'h0F);

    // Back-to-back frames, no idle cycle in between.
    frame(8'h5A, 8'h0F, 1'b1, 1'b0);
    frame(8'hA5, 8'h5A, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("b2b_partial", uio_out, {2'b00, 3'd3, 1'b1, 1'b1, 1'b0});
    chk("b2b_partial_out", uo_out, 8'hA5);

    // Asynchronous reset mid-frame, checked before any further rising edge.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_uo_out", uo_out, 8'h00);
    chk("async_rst_uio_out", uio_out, 8'h00);
    chk("async_rst_uio_oe", uio_oe, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;

    frame(8'hA5, 8'h00, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
